// File: rtl/buck_pi_voltage_controller.sv
// Discrete PI voltage loop with one shared multiplier; emits a clamped duty command for the PWM comparator.
// Latency: a clock_enable sampled at edge k produces duty_cycle/duty_valid at edge k+5 (6-state FSM).
// No backpressure: strobes arriving while busy are dropped and flagged on sticky overrun. Option macro: PI_ANTIWINDUP_EN.
module buck_pi_voltage_controller #(
    parameter int model_data_width    = 25,
    parameter int model_decimal_width = 16,
    parameter int duty_width          = 16,
    parameter int acc_width           = 48
) (
    input  logic                        aclk,
    input  logic                        resetn,
    input  logic                        clock_enable,
    input  logic                        enable,
    input  logic [model_data_width-1:0] voltage_ref,
    input  logic [model_data_width-1:0] voltage_fb,
    input  logic [model_data_width-1:0] kp,
    input  logic [model_data_width-1:0] ki,
    input  logic [duty_width-1:0]       duty_max,
    output logic [duty_width-1:0]       duty_cycle,
    output logic                        duty_valid,
    output logic                        saturated,
    output logic                        busy,
    output logic                        overrun
);

    localparam int DW = model_data_width;
    localparam int FW = model_decimal_width;
    localparam int EW = model_data_width + 1;
    localparam int AW = acc_width;
    localparam int PW = 2 * EW;

`ifdef PI_ANTIWINDUP_EN
    localparam bit ANTIWINDUP = 1'b1;
`else
    localparam bit ANTIWINDUP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MULP, S_MULI, S_INTEG, S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0]         ref_q, fb_q, kp_q, ki_q;
    logic [duty_width-1:0] dmax_q;
    logic signed [EW-1:0]  err;
    logic signed [AW-1:0]  p_term, di_term, integ;
    logic                  sat_hi, sat_lo;

    logic signed [EW-1:0]  gain_op;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  mult_val;
    logic signed [AW-1:0]  integ_sum, integ_max, u_val, dmax_ext;
    logic                  hold_integ;

    // Shared multiplier: gain operand selected by state; full-precision product, truncated only by the Q16 shift.
    always_comb begin
        gain_op    = (state == S_MULI) ? $signed({1'b0, ki_q}) : $signed({1'b0, kp_q});
        prod       = err * gain_op;
        mult_val   = AW'(prod >>> FW);
        integ_sum  = integ + di_term;
        integ_max  = $signed({{(AW-duty_width-FW){1'b0}}, dmax_q, {FW{1'b0}}});
        dmax_ext   = $signed({{(AW-duty_width){1'b0}}, dmax_q});
        u_val      = (p_term + integ) >>> FW;
        hold_integ = ANTIWINDUP &&
                     ((sat_hi && !di_term[AW-1] && (di_term != '0)) ||
                      (sat_lo &&  di_term[AW-1]));
    end

    // State register.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: fixed one-state-per-cycle walk; enable low forces IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (clock_enable) state_nxt = S_ERR;
                S_ERR:   state_nxt = S_MULP;
                S_MULP:  state_nxt = S_MULI;
                S_MULI:  state_nxt = S_INTEG;
                S_INTEG: state_nxt = S_OUT;
                S_OUT:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    // Datapath: operand capture, error, products, integrator, output clamp and status flags.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            ref_q      <= '0;
            fb_q       <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            dmax_q     <= '0;
            err        <= '0;
            p_term     <= '0;
            di_term    <= '0;
            integ      <= '0;
            duty_cycle <= '0;
            duty_valid <= 1'b0;
            saturated  <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
            overrun    <= 1'b0;
        end else if (!enable) begin
            integ      <= '0;
            duty_cycle <= '0;
            duty_valid <= 1'b0;
            saturated  <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (clock_enable && (state != S_IDLE))
                overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (clock_enable) begin
                        ref_q  <= voltage_ref;
                        fb_q   <= voltage_fb;
                        kp_q   <= kp;
                        ki_q   <= ki;
                        dmax_q <= duty_max;
                    end
                end
                S_ERR:  err     <= $signed({1'b0, ref_q}) - $signed({1'b0, fb_q});
                S_MULP: p_term  <= mult_val;
                S_MULI: di_term <= mult_val;
                S_INTEG: begin
                    if (!hold_integ) begin
                        if (integ_sum[AW-1])
                            integ <= '0;
                        else if (integ_sum > integ_max)
                            integ <= integ_max;
                        else
                            integ <= integ_sum;
                    end
                end
                S_OUT: begin
                    duty_valid <= 1'b1;
                    if (u_val[AW-1]) begin
                        duty_cycle <= '0;
                        saturated  <= 1'b1;
                        sat_lo     <= 1'b1;
                        sat_hi     <= 1'b0;
                    end else if (u_val > dmax_ext) begin
                        duty_cycle <= dmax_q;
                        saturated  <= 1'b1;
                        sat_lo     <= 1'b0;
                        sat_hi     <= 1'b1;
                    end else begin
                        duty_cycle <= u_val[duty_width-1:0];
                        saturated  <= 1'b0;
                        sat_lo     <= 1'b0;
                        sat_hi     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_buck_pi_voltage_controller.sv
module tb_buck_pi_voltage_controller;

    logic        aclk = 1'b0;
    logic        resetn;
    logic        clock_enable;
    logic        enable;
    logic [24:0] voltage_ref, voltage_fb, kp, ki;
    logic [15:0] duty_max;
    logic [15:0] duty_cycle;
    logic        duty_valid, saturated, busy, overrun;

    buck_pi_voltage_controller dut (
        .aclk(aclk), .resetn(resetn), .clock_enable(clock_enable), .enable(enable),
        .voltage_ref(voltage_ref), .voltage_fb(voltage_fb), .kp(kp), .ki(ki),
        .duty_max(duty_max), .duty_cycle(duty_cycle), .duty_valid(duty_valid),
        .saturated(saturated), .busy(busy), .overrun(overrun)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] duty;
        logic        sat;
        int          at_cyc;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every duty_valid pulse is matched against the oldest expected update.
    always @(negedge aclk) begin
        if (resetn === 1'b1 && duty_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_duty_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("duty_cycle", {16'd0, duty_cycle}, {16'd0, e.duty});
                check("saturated", {31'd0, saturated}, {31'd0, e.sat});
                check("latency_cycle", cyc, e.at_cyc);
            end
        end
    end

    // One strobe; the expected update is due 5 edges after the sampling edge.
    task automatic strobe(input logic [15:0] ed, input logic es);
        exp_t e;
        @(negedge aclk);
        clock_enable = 1'b1;
        e.duty = ed; e.sat = es; e.at_cyc = cyc + 6;
        exp_q.push_back(e);
        @(negedge aclk);
        clock_enable = 1'b0;
        repeat (6) @(negedge aclk);
    endtask

    task automatic drop_enable();
        @(negedge aclk);
        enable = 1'b0;
        @(negedge aclk);
        enable = 1'b1;
    endtask

    task automatic set_in(input logic [24:0] r, input logic [24:0] f,
                          input logic [24:0] p, input logic [24:0] i, input logic [15:0] m);
        voltage_ref = r; voltage_fb = f; kp = p; ki = i; duty_max = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; clock_enable = 1'b0; enable = 1'b1;
        set_in(25'd0, 25'd0, 25'd0, 25'd0, 16'd0);
        repeat (3) @(negedge aclk);
        check("reset_duty", {16'd0, duty_cycle}, 32'd0);
        check("reset_valid", {31'd0, duty_valid}, 32'd0);
        check("reset_sat", {31'd0, saturated}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        resetn = 1'b1;

        // 1: proportional only, 6 V error * 100 counts/V = 600
        set_in(25'd393216, 25'd0, 25'd6553600, 25'd0, 16'd6666);
        strobe(16'd600, 1'b0);

        // 2: integral only, 1 V * 10 counts/V per sample
        drop_enable();
        set_in(25'd65536, 25'd0, 25'd0, 25'd655360, 16'd6666);
        strobe(16'd10, 1'b0);
        strobe(16'd20, 1'b0);
        strobe(16'd30, 1'b0);

        // 3: negative error clamps to 0; large error clamps to duty_max (kp kept within 25-bit range)
        drop_enable();
        set_in(25'd0, 25'd393216, 25'd6553600, 25'd0, 16'd6666);
        strobe(16'd0, 1'b1);
        set_in(25'd1310720, 25'd0, 25'd32768000, 25'd0, 16'd5000);
        strobe(16'd5000, 1'b1);

        // 4: second strobe 2 cycles later is dropped and flags overrun
        drop_enable();
        check("overrun_cleared_pre", {31'd0, overrun}, 32'd0);
        set_in(25'd65536, 25'd0, 25'd6553600, 25'd0, 16'd6666);
        begin
            exp_t e;
            @(negedge aclk);
            clock_enable = 1'b1;
            e.duty = 16'd100; e.sat = 1'b0; e.at_cyc = cyc + 6;
            exp_q.push_back(e);
            @(negedge aclk);
            clock_enable = 1'b0;
            check("busy_during_calc", {31'd0, busy}, 32'd1);
            @(negedge aclk);
            clock_enable = 1'b1;
            @(negedge aclk);
            clock_enable = 1'b0;
            repeat (8) @(negedge aclk);
        end
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        drop_enable();
        check("overrun_cleared", {31'd0, overrun}, 32'd0);

        // 5: enable dropped in MULI aborts the update and clears the integrator
        set_in(25'd65536, 25'd0, 25'd0, 25'd655360, 16'd6666);
        strobe(16'd10, 1'b0);
        @(negedge aclk); clock_enable = 1'b1;
        @(negedge aclk); clock_enable = 1'b0;
        @(negedge aclk);
        @(negedge aclk); enable = 1'b0;
        @(negedge aclk);
        check("abort_duty", {16'd0, duty_cycle}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, duty_valid}, 32'd0);
        enable = 1'b1;
        repeat (6) @(negedge aclk);
        strobe(16'd10, 1'b0);

        // 6: integrator clamp at duty_max, then unwinds on negative error
        drop_enable();
        set_in(25'd65536, 25'd0, 25'd0, 25'd3276800, 16'd100);
        strobe(16'd50, 1'b0);
        for (int i = 0; i < 4; i++) strobe(16'd100, 1'b0);
        voltage_fb = 25'd131072;
        strobe(16'd50, 1'b0);

        // 7: duty_max = 0 forces zero output and reports saturation
        drop_enable();
        set_in(25'd65536, 25'd0, 25'd6553600, 25'd655360, 16'd0);
        strobe(16'd0, 1'b1);

        repeat (10) @(negedge aclk);
        check("all_updates_seen", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
